// File: rtl/score_display.sv
// Score readout: high-score tracker, sequential double-dabble to BCD, four-digit active-low scan.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks leading-zero digits 3..1.
module score_display #(
  parameter int SCAN_DIV = 1
) (
  input  logic        segclk,
  input  logic        rst,
  input  logic        en,
  input  logic [19:0] score,
  input  logic        show_high,
  output logic [19:0] high,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state_q, state_d;
  logic [13:0] bin_q, bin_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        src_high_q, src_high_d;
  logic [15:0] disp_bcd_q, disp_bcd_d;
  logic        disp_high_q, disp_high_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  dig_q, dig_d;
  logic [19:0] high_q, high_d;
  logic [7:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;

  logic [19:0] src;
  logic [13:0] sat;
  logic [15:0] bcd_adj;
  logic [3:0]  nib;
  logic [3:0]  lz;
  logic        blank;
  logic        dp_n;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    src_high_d  = src_high_q;
    disp_bcd_d  = disp_bcd_q;
    disp_high_d = disp_high_q;
    div_d       = div_q;
    dig_d       = dig_q;
    high_d      = high_q;

    if (score > high_q) high_d = score;

    // Uses the pre-update high so a simultaneous new record shows next conversion.
    src = show_high ? high_q : score;
    sat = (src > 20'd9999) ? 14'd9999 : src[13:0];

    for (int i = 0; i < 4; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end

    case (state_q)
      IDLE: begin
        if (en) begin
          bin_d      = sat;
          bcd_d      = 16'd0;
          src_high_d = show_high;
          cnt_d      = 4'd13;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      DONE: begin
        disp_bcd_d  = bcd_q;
        disp_high_d = src_high_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (div_q == 8'(SCAN_DIV - 1)) begin
      div_d = 8'd0;
      dig_d = dig_q + 2'd1;
    end else begin
      div_d = div_q + 8'd1;
    end

    nib = disp_bcd_q[{dig_q, 2'b00} +: 4];
    lz[0] = 1'b0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    lz[3] = (disp_bcd_q[15:12] == 4'd0);
    lz[2] = lz[3] && (disp_bcd_q[11:8] == 4'd0);
    lz[1] = lz[2] && (disp_bcd_q[7:4] == 4'd0);
`else
    lz[3:1] = 3'b000;
`endif
    blank = lz[dig_q];
    dp_n  = !((dig_q == 2'd0) && disp_high_q);

    if (en) begin
      an_d  = ~(4'b0001 << dig_q);
      seg_d = {dp_n, blank ? 7'h7F : seg7(nib)};
    end else begin
      an_d  = 4'hF;
      seg_d = 8'hFF;
    end
  end

  always_ff @(posedge segclk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      src_high_q  <= 1'b0;
      disp_bcd_q  <= '0;
      disp_high_q <= 1'b0;
      div_q       <= '0;
      dig_q       <= '0;
      high_q      <= '0;
      seg_q       <= 8'hFF;
      an_q        <= 4'hF;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      src_high_q  <= src_high_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_high_q <= disp_high_d;
      div_q       <= div_d;
      dig_q       <= dig_d;
      high_q      <= high_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign high = high_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: reset, digits, saturation, blanking, high score, enable.
module tb_score_display;

  logic        segclk = 1'b0;
  logic        rst;
  logic        en;
  logic [19:0] score;
  logic        show_high;
  logic [19:0] high;
  logic [7:0]  seg;
  logic [3:0]  an;

  int total = 0;
  int bad   = 0;

  score_display #(.SCAN_DIV(1)) dut (
    .segclk(segclk), .rst(rst), .en(en), .score(score),
    .show_high(show_high), .high(high), .seg(seg), .an(an)
  );

  always #5 segclk = ~segclk;

  // Waits (bounded) for the anode pattern and returns its segments, or X on timeout.
  task automatic get_digit(input logic [3:0] want, output logic [7:0] s);
    s = 8'hxx;
    for (int i = 0; i < 16; i++) begin
      @(negedge segclk);
      if (an === want) begin
        s = seg;
        return;
      end
    end
  endtask

  task automatic settle();
    repeat (40) @(posedge segclk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge segclk);
    @(negedge segclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] s;
    en = 1'b1; show_high = 1'b0; score = 20'd300;
    repeat (4) @(posedge segclk);
    #3 rst = 1'b1;
    #1;
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL reset_seg got=%h want=ff", seg); end
    total++; if (an !== 4'hF) begin bad++; $display("FAIL reset_an got=%h want=f", an); end
    total++; if (high !== 20'd0) begin bad++; $display("FAIL reset_high got=%0d want=0", high); end
    score = 20'd0;
    @(negedge segclk);
    rst = 1'b0;
    repeat (17) @(posedge segclk);
    get_digit(4'hE, s);
    total++; if (s !== 8'hC0) begin bad++; $display("FAIL reset_digit0 got=%h want=c0", s); end
  endtask

  task automatic test_basic_digits();
    logic [3:0] an_exp [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] seg_exp[4] = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    logic [7:0] s;
    score = 20'd1234; show_high = 1'b0; en = 1'b1;
    settle();
    get_digit(4'hE, s);
    for (int k = 0; k < 8; k++) begin
      total++;
      if (an !== an_exp[k%4] || seg !== seg_exp[k%4]) begin
        bad++;
        $display("FAIL basic_seq%0d got an=%h seg=%h want an=%h seg=%h", k, an, seg, an_exp[k%4], seg_exp[k%4]);
      end
      @(negedge segclk);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] an_tab[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] s;
    score = 20'd54321;
    settle();
    for (int k = 0; k < 4; k++) begin
      get_digit(an_tab[k], s);
      total++; if (s !== 8'h90) begin bad++; $display("FAIL sat54321_d%0d got=%h want=90", k, s); end
    end
    score = 20'd10000;
    settle();
    get_digit(4'h7, s);
    total++; if (s !== 8'h90) begin bad++; $display("FAIL sat10000_d3 got=%h want=90", s); end
    score = 20'd9998;
    settle();
    get_digit(4'hE, s);
    total++; if (s !== 8'h80) begin bad++; $display("FAIL sat9998_d0 got=%h want=80", s); end
  endtask

  task automatic test_leading_zero();
    logic [3:0] an_tab[4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [7:0] s;
    logic [7:0] lead;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    lead = 8'hFF;
`else
    lead = 8'hC0;
`endif
    score = 20'd7;
    settle();
    get_digit(4'hE, s);
    total++; if (s !== 8'hF8) begin bad++; $display("FAIL lz_d0 got=%h want=f8", s); end
    for (int k = 1; k < 4; k++) begin
      get_digit(an_tab[k], s);
      total++; if (s !== lead) begin bad++; $display("FAIL lz_d%0d got=%h want=%h", k, s, lead); end
    end
  endtask

  task automatic test_high_score();
    logic [7:0] s;
    logic [7:0] d3;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    d3 = 8'hFF;
`else
    d3 = 8'hC0;
`endif
    do_reset();
    show_high = 1'b0; score = 20'd500;
    repeat (3) @(posedge segclk);
    score = 20'd200;
    repeat (3) @(posedge segclk);
    #1;
    total++; if (high !== 20'd500) begin bad++; $display("FAIL high_track got=%0d want=500", high); end
    show_high = 1'b1;
    settle();
    get_digit(4'hE, s);
    total++; if (s !== 8'h40) begin bad++; $display("FAIL high_d0 got=%h want=40", s); end
    get_digit(4'hD, s);
    total++; if (s !== 8'hC0) begin bad++; $display("FAIL high_d1 got=%h want=c0", s); end
    get_digit(4'hB, s);
    total++; if (s !== 8'h92) begin bad++; $display("FAIL high_d2 got=%h want=92", s); end
    get_digit(4'h7, s);
    total++; if (s !== d3) begin bad++; $display("FAIL high_d3 got=%h want=%h", s, d3); end
    show_high = 1'b0;
  endtask

  task automatic test_enable();
    logic [7:0] s;
    score = 20'd200;
    settle();
    @(negedge segclk);
    en = 1'b0;
    @(posedge segclk); #1;
    total++; if (an !== 4'hF) begin bad++; $display("FAIL en_off_an got=%h want=f", an); end
    total++; if (seg !== 8'hFF) begin bad++; $display("FAIL en_off_seg got=%h want=ff", seg); end
    score = 20'd900;
    repeat (2) @(posedge segclk); #1;
    total++; if (high !== 20'd900) begin bad++; $display("FAIL en_off_high got=%0d want=900", high); end
    total++; if (an !== 4'hF) begin bad++; $display("FAIL en_off_hold got=%h want=f", an); end
    @(negedge segclk);
    en = 1'b1;
    repeat (17) @(posedge segclk);
    get_digit(4'hB, s);
    total++; if (s !== 8'h90) begin bad++; $display("FAIL en_on_d2 got=%h want=90", s); end
    get_digit(4'hE, s);
    total++; if (s !== 8'hC0) begin bad++; $display("FAIL en_on_d0 got=%h want=c0", s); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    score = 20'd1111;
    repeat (5) @(posedge segclk);
    score = 20'd2222;
    settle();
    get_digit(4'hD, s);
    total++; if (s !== 8'hA4) begin bad++; $display("FAIL b2b_d1 got=%h want=a4", s); end
    get_digit(4'h7, s);
    total++; if (s !== 8'hA4) begin bad++; $display("FAIL b2b_d3 got=%h want=a4", s); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; score = 20'd0; show_high = 1'b0;
    repeat (2) @(posedge segclk);
    @(negedge segclk);
    rst = 1'b0;
    test_reset();
    test_basic_digits();
    test_saturation();
    test_leading_zero();
    test_high_score();
    test_enable();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
